noc_output_switch_rr: RTL

NOC_OUTPUT_SWITCH_RR -- requirements
Module: noc_output_switch_rr

---
 rtl/noc_output_switch_rr_if.sv | 34 +++
 rtl/noc_output_switch_rr.sv | 132 +++++++++++++
 2 files changed

// File: rtl/noc_output_switch_rr_if.sv
// Port bundle for the round-robin NoC output switch: per-port input flits,
// the FIFO head towards downstream, and status.
interface noc_output_switch_rr_if #(
    parameter int unsigned N_PORTS    = 5,
    parameter int unsigned FLIT_WIDTH = 130,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(N_PORTS);

    logic [N_PORTS-1:0]                 in_valid;
    logic [N_PORTS-1:0][FLIT_WIDTH-1:0] in_flit;
    logic [N_PORTS-1:0]                 in_ready;
    logic                               out_valid;
    logic [FLIT_WIDTH-1:0]              out_flit;
    logic                               out_ready;
    logic                               o_free;
    logic [CW-1:0]                      o_count;
    logic                               o_almost_full;
    logic                               o_locked;
    logic [OW-1:0]                      o_owner;

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_flit, o_free, o_count,
               o_almost_full, o_locked, o_owner
    );

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_flit, o_free, o_count,
               o_almost_full, o_locked, o_owner
    );
endinterface

// File: rtl/noc_output_switch_rr.sv
// N-input output port: round-robin packet arbiter with wormhole lock feeding
// a first-word-fall-through output FIFO.
module noc_output_switch_rr #(
    parameter int unsigned N_PORTS      = 5,
    parameter int unsigned FLIT_WIDTH   = 130,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned AF_THRESHOLD = FIFO_DEPTH - 2
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    noc_output_switch_rr_if.slave sw
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(N_PORTS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                r_state, w_state_nx;
    logic [OW-1:0]         r_ptr, w_ptr_nx;
    logic [OW-1:0]         r_owner, w_owner_nx;
    logic [OW-1:0]         w_grant, w_sel, w_sel_inc;
    logic                  w_grant_vld;
    logic [N_PORTS-1:0]    w_req, w_ready;
    logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_full, w_push, w_pop, w_tail;
    logic [FLIT_WIDTH-1:0] w_push_flit;

    // Header requests; only these compete for a new grant
    always_comb begin
        w_req = '0;
        for (int i = 0; i < int'(N_PORTS); i++)
            w_req[i] = sw.in_valid[i] & sw.in_flit[i][FLIT_WIDTH-1];
    end

    // First requester at or after r_ptr; scanning downward lets the nearest win
    always_comb begin
        int idx;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= int'(N_PORTS)) idx = idx - int'(N_PORTS);
            if (w_req[idx]) begin
                w_grant     = OW'(idx);
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_sel     = (r_state == S_LOCKED) ? r_owner : w_grant;
    assign w_sel_inc = (w_sel == OW'(N_PORTS - 1)) ? '0 : w_sel + OW'(1);

    always_comb begin
        w_ready = '0;
        if (!noc_rst && !w_full && (r_state == S_LOCKED || w_grant_vld))
            w_ready[w_sel] = 1'b1;
    end

    assign w_push      = |(sw.in_valid & w_ready);
    assign w_push_flit = sw.in_flit[w_sel];
    assign w_tail      = w_push_flit[FLIT_WIDTH-2];
    assign w_pop       = (r_count != '0) & sw.out_ready;

    // Arbiter next state
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_owner_nx = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_owner_nx = w_sel;
                    if (w_tail) w_ptr_nx   = w_sel_inc;
                    else        w_state_nx = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_push && w_tail) begin
                    w_state_nx = S_IDLE;
                    w_ptr_nx   = w_sel_inc;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_owner <= w_owner_nx;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_flit;
    end

    assign sw.in_ready      = w_ready;
    assign sw.o_free        = w_push;
    assign sw.out_valid     = (r_count != '0);
    assign sw.out_flit      = r_mem[r_rd_ptr];
    assign sw.o_count       = r_count;
    assign sw.o_almost_full = (r_count >= CW'(AF_THRESHOLD));
    assign sw.o_locked      = (r_state == S_LOCKED);
    assign sw.o_owner       = r_owner;
endmodule
